// File: rtl/chess_pkg.sv
// Shared chess datapath definitions: piece codes, colour tests, ray tables
// and the move generator state encoding.
package chess_pkg;

    localparam logic [3:0] PC_EMPTY     = 4'h0;
    localparam logic [3:0] PC_W_PAWN    = 4'h1;
    localparam logic [3:0] PC_W_BISHOP  = 4'h2;
    localparam logic [3:0] PC_W_KNIGHT  = 4'h3;
    localparam logic [3:0] PC_W_ROOK    = 4'h4;
    localparam logic [3:0] PC_W_QUEEN   = 4'h5;
    localparam logic [3:0] PC_W_KING    = 4'h6;
    localparam logic [3:0] PC_B_PAWN    = 4'h7;
    localparam logic [3:0] PC_B_BISHOP  = 4'h8;
    localparam logic [3:0] PC_B_KNIGHT  = 4'h9;
    localparam logic [3:0] PC_B_ROOK    = 4'hA;
    localparam logic [3:0] PC_B_QUEEN   = 4'hB;
    localparam logic [3:0] PC_B_KING    = 4'hC;
    localparam logic [3:0] PC_EMPTY_ALT = 4'hD;

    localparam logic [5:0] W_KING_HOME = 6'd60;
    localparam logic [5:0] B_KING_HOME = 6'd4;

    localparam logic signed [3:0] Z  = 4'sd0;
    localparam logic signed [3:0] P1 = 4'sd1;
    localparam logic signed [3:0] P2 = 4'sd2;
    localparam logic signed [3:0] M1 = -4'sd1;
    localparam logic signed [3:0] M2 = -4'sd2;

    typedef enum logic [2:0] {
        PT_NONE, PT_PAWN, PT_BISHOP, PT_KNIGHT, PT_ROOK, PT_QUEEN, PT_KING
    } piece_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_STEP, ST_WAIT, ST_EVAL, ST_NEXTDIR, ST_FIN
    } state_t;

    typedef struct packed {
        logic signed [3:0] dr;
        logic signed [3:0] dc;
    } delta_t;

    function automatic logic is_empty(input logic [3:0] c);
        return (c == PC_EMPTY) || (c == PC_EMPTY_ALT);
    endfunction

    function automatic logic is_white(input logic [3:0] c);
        return (c >= PC_W_PAWN) && (c <= PC_W_KING);
    endfunction

    function automatic logic is_black(input logic [3:0] c);
        return (c >= PC_B_PAWN) && (c <= PC_B_KING);
    endfunction

    function automatic logic is_enemy(input logic [3:0] mover, input logic [3:0] c);
        return (is_white(mover) && is_black(c)) || (is_black(mover) && is_white(c));
    endfunction

    function automatic piece_t piece_type(input logic [3:0] c);
        case (c)
            PC_W_PAWN,   PC_B_PAWN:   return PT_PAWN;
            PC_W_BISHOP, PC_B_BISHOP: return PT_BISHOP;
            PC_W_KNIGHT, PC_B_KNIGHT: return PT_KNIGHT;
            PC_W_ROOK,   PC_B_ROOK:   return PT_ROOK;
            PC_W_QUEEN,  PC_B_QUEEN:  return PT_QUEEN;
            PC_W_KING,   PC_B_KING:   return PT_KING;
            default:                  return PT_NONE;
        endcase
    endfunction

    // Index 0 = N, proceeding clockwise to 7 = NW.
    function automatic delta_t dir_delta(input logic [2:0] d);
        case (d)
            3'd0:    return '{dr: M1, dc: Z };
            3'd1:    return '{dr: M1, dc: P1};
            3'd2:    return '{dr: Z,  dc: P1};
            3'd3:    return '{dr: P1, dc: P1};
            3'd4:    return '{dr: P1, dc: Z };
            3'd5:    return '{dr: P1, dc: M1};
            3'd6:    return '{dr: Z,  dc: M1};
            default: return '{dr: M1, dc: M1};
        endcase
    endfunction

    function automatic delta_t knight_delta(input logic [2:0] d);
        case (d)
            3'd0:    return '{dr: M2, dc: M1};
            3'd1:    return '{dr: M2, dc: P1};
            3'd2:    return '{dr: M1, dc: P2};
            3'd3:    return '{dr: P1, dc: P2};
            3'd4:    return '{dr: P2, dc: P1};
            3'd5:    return '{dr: P2, dc: M1};
            3'd6:    return '{dr: P1, dc: M2};
            default: return '{dr: M1, dc: M2};
        endcase
    endfunction

    // Pawns reuse the ray table: straight ahead plus the two forward diagonals.
    function automatic logic [7:0] dir_set(input piece_t pt, input logic white);
        case (pt)
            PT_NONE:   return 8'h00;
            PT_ROOK:   return 8'h55;
            PT_BISHOP: return 8'hAA;
            PT_PAWN:   return white ? 8'h83 : 8'h38;
            default:   return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] lowest_dir(input logic [7:0] m);
        logic [2:0] d;
        logic       found;
        d     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[i] && !found) begin
                d     = 3'(i);
                found = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/movegen_step.sv
// Origin square plus signed row/col delta; flags results that leave the board.
module movegen_step
    import chess_pkg::*;
(
    input  logic [5:0] origin,
    input  delta_t     delta,
    output logic [5:0] square,
    output logic       on_board
);

    logic signed [3:0] row;
    logic signed [3:0] col;

    // Reachable results span -4..11, so bit 3 alone marks anything outside 0..7.
    always_comb begin
        row      = $signed({1'b0, origin[5:3]}) + delta.dr;
        col      = $signed({1'b0, origin[2:0]}) + delta.dc;
        on_board = !row[3] && !col[3];
        square   = {row[2:0], col[2:0]};
    end

endmodule

// File: rtl/move_generator.sv
// Legal-target generator: walks piece rays over the board lookup port and
// builds a 64-bit target mask. Castling probes are built with MOVEGEN_CASTLE_EN.
module move_generator
    import chess_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  sel_pos,
    input  logic [3:0]  sel_code,
    input  logic        white_castle,
    input  logic        black_castle,
    output logic [5:0]  scan_xy,
    input  logic [3:0]  sq_code,
    output logic [63:0] possible_moves,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic [5:0]        org_pos, cur_pos, step_sq, step_origin, castle_mark_sq;
    logic [3:0]        piece;
    piece_t            ptype;
    logic              mover_white;
    logic [2:0]        dir, next_dir;
    logic [7:0]        dir_rem;
    logic              first_step, at_start;
    logic [WW-1:0]     wait_cnt;
    logic              wait_done;
    logic              in_castle, castle_side, castle_go, castle_last, castle_ok;
    logic [2:0]        cstep;
    logic signed [3:0] castle_dc;
    logic              sq_empty, sq_enemy, mark_hit, cont;
    delta_t            step_delta;
    logic              on_board, issue;

    assign ptype       = piece_type(piece);
    assign mover_white = is_white(piece);
    assign next_dir    = lowest_dir(dir_rem);
    assign wait_done   = (wait_cnt == WAIT_LAST);

`ifdef MOVEGEN_CASTLE_EN
    always_comb begin
        castle_go = 1'b0;
        if (ptype == PT_KING) begin
            if (mover_white) castle_go = (org_pos == W_KING_HOME) && !white_castle;
            else             castle_go = (org_pos == B_KING_HOME) && !black_castle;
        end
    end
`else
    logic unused_castle;
    assign castle_go     = 1'b0;
    assign unused_castle = white_castle ^ black_castle;
`endif

    // First probe of a ray starts from the origin; continuations from the last probe.
    always_comb begin
        castle_dc   = castle_side ? -$signed({1'b0, cstep}) : $signed({1'b0, cstep});
        step_origin = (state == ST_EVAL) ? cur_pos : org_pos;
        step_delta  = dir_delta(dir);
        if (in_castle)               step_delta = '{dr: Z, dc: castle_dc};
        else if (ptype == PT_KNIGHT) step_delta = knight_delta(dir);
    end

    movegen_step u_step (
        .origin   (step_origin),
        .delta    (step_delta),
        .square   (step_sq),
        .on_board (on_board)
    );

    always_comb begin
        sq_empty = is_empty(sq_code);
        sq_enemy = is_enemy(piece, sq_code);
        at_start = (org_pos[5:3] == (mover_white ? 3'd6 : 3'd1));
        mark_hit = 1'b0;
        cont     = 1'b0;
        unique case (ptype)
            PT_PAWN: begin
                if (!dir[0]) begin
                    mark_hit = sq_empty;
                    cont     = sq_empty && first_step && at_start;
                end else begin
                    mark_hit = sq_enemy;
                end
            end
            PT_KING, PT_KNIGHT: mark_hit = sq_empty || sq_enemy;
            default: begin
                mark_hit = sq_empty || sq_enemy;
                cont     = sq_empty;
            end
        endcase
        castle_last    = castle_side ? (cstep == 3'd4) : (cstep == 3'd3);
        castle_ok      = castle_last ? (sq_code == (mover_white ? PC_W_ROOK : PC_B_ROOK)) : sq_empty;
        castle_mark_sq = castle_side ? (org_pos - 6'd2) : (org_pos + 6'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_INIT;
            ST_INIT:    state_nxt = (ptype == PT_NONE) ? ST_FIN : ST_NEXTDIR;
            ST_NEXTDIR: begin
                if (in_castle)             state_nxt = castle_side ? ST_FIN : ST_STEP;
                else if (dir_rem != '0)    state_nxt = ST_STEP;
                else if (castle_go)        state_nxt = ST_STEP;
                else                       state_nxt = ST_FIN;
            end
            ST_STEP:    state_nxt = on_board ? ST_WAIT : ST_NEXTDIR;
            ST_WAIT:    if (wait_done) state_nxt = ST_EVAL;
            ST_EVAL: begin
                if (in_castle) state_nxt = (castle_ok && !castle_last) ? ST_STEP : ST_NEXTDIR;
                else           state_nxt = (cont && on_board) ? ST_WAIT : ST_NEXTDIR;
            end
            ST_FIN:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_FIN);
        issue = ((state == ST_STEP) || (state == ST_EVAL)) && (state_nxt == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            org_pos        <= '0;
            piece          <= '0;
            cur_pos        <= '0;
            dir            <= '0;
            dir_rem        <= '0;
            first_step     <= 1'b0;
            wait_cnt       <= '0;
            in_castle      <= 1'b0;
            castle_side    <= 1'b0;
            cstep          <= '0;
            scan_xy        <= '0;
            possible_moves <= '0;
        end else begin
            if (issue) begin
                scan_xy  <= step_sq;
                cur_pos  <= step_sq;
                wait_cnt <= '0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        org_pos        <= sel_pos;
                        piece          <= sel_code;
                        possible_moves <= '0;
                        in_castle      <= 1'b0;
                        castle_side    <= 1'b0;
                        cstep          <= '0;
                    end
                end
                ST_INIT: dir_rem <= dir_set(ptype, mover_white);
                ST_NEXTDIR: begin
                    if (in_castle) begin
                        castle_side <= 1'b1;
                        cstep       <= 3'd1;
                    end else if (dir_rem != '0) begin
                        dir               <= next_dir;
                        dir_rem[next_dir] <= 1'b0;
                        first_step        <= 1'b1;
                    end else if (castle_go) begin
                        in_castle   <= 1'b1;
                        castle_side <= 1'b0;
                        cstep       <= 3'd1;
                    end
                end
                ST_WAIT: wait_cnt <= wait_cnt + 1'b1;
                ST_EVAL: begin
                    if (in_castle) begin
                        if (castle_ok && castle_last)  possible_moves[castle_mark_sq] <= 1'b1;
                        if (castle_ok && !castle_last) cstep <= cstep + 3'd1;
                    end else begin
                        if (mark_hit) possible_moves[cur_pos] <= 1'b1;
                        if (issue)    first_step <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_generator.sv
// Directed bench for move_generator with a one-cycle-latency board model.
module tb_move_generator;

    localparam int BUDGET = 2 + 35 * 2 + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  sel_pos;
    logic [3:0]  sel_code;
    logic        white_castle;
    logic        black_castle;
    logic [5:0]  scan_xy;
    logic [3:0]  sq_code;
    logic [63:0] possible_moves;
    logic        busy;
    logic        done;

    logic [3:0]  board [64];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) sq_code <= board[scan_xy];

    move_generator #(.RD_LAT(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sel_pos        (sel_pos),
        .sel_code       (sel_code),
        .white_castle   (white_castle),
        .black_castle   (black_castle),
        .scan_xy        (scan_xy),
        .sq_code        (sq_code),
        .possible_moves (possible_moves),
        .busy           (busy),
        .done           (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'h0;
    endtask

    task automatic init_board();
        logic [3:0] back_b [8];
        logic [3:0] back_w [8];
        back_b = '{4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};
        back_w = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
        clear_board();
        for (int c = 0; c < 8; c++) begin
            board[c]      = back_b[c];
            board[8 + c]  = 4'h7;
            board[48 + c] = 4'h1;
            board[56 + c] = back_w[c];
        end
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 1;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic run_gen(input string tag, input logic [5:0] p, input logic [3:0] c);
        @(negedge clk);
        sel_pos  = p;
        sel_code = c;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
        wait_done(tag);
    endtask

    logic [63:0] exp;
    logic [63:0] rook27;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sel_pos      = '0;
        sel_code     = '0;
        white_castle = 1'b0;
        black_castle = 1'b0;
        clear_board();
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_mask", possible_moves, 64'd0);
        check_eq("rst_scan", {58'd0, scan_xy}, 64'd0);
        rst_n = 1'b1;

        // White pawn double step from the opening position.
        init_board();
        run_gen("wpawn", 6'd52, 4'h1);
        exp = '0; exp[44] = 1'b1; exp[36] = 1'b1;
        check_eq("wpawn_mask", possible_moves, exp);
        repeat (3) @(negedge clk);
        check_eq("hold_mask", possible_moves, exp);
        check_eq("hold_done", {63'd0, done}, 64'd0);
        check_eq("hold_busy", {63'd0, busy}, 64'd0);

        run_gen("bpawn", 6'd12, 4'h7);
        exp = '0; exp[20] = 1'b1; exp[28] = 1'b1;
        check_eq("bpawn_mask", possible_moves, exp);

        run_gen("knight", 6'd62, 4'h3);
        exp = '0; exp[45] = 1'b1; exp[47] = 1'b1;
        check_eq("knight_mask", possible_moves, exp);

        // Blocked pawn with two diagonal captures.
        clear_board();
        board[52] = 4'h1; board[44] = 4'h9; board[43] = 4'h7; board[45] = 4'hA;
        run_gen("pcap", 6'd52, 4'h1);
        exp = '0; exp[43] = 1'b1; exp[45] = 1'b1;
        check_eq("pcap_mask", possible_moves, exp);

        clear_board();
        board[27] = 4'h4;
        run_gen("rook", 6'd27, 4'h4);
        rook27 = '0;
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                rook27[24 + i] = 1'b1;
                rook27[i * 8 + 3] = 1'b1;
            end
        end
        check_eq("rook_mask", possible_moves, rook27);

        run_gen("queen", 6'd27, 4'h5);
        exp = rook27;
        exp[20] = 1'b1; exp[13] = 1'b1; exp[6]  = 1'b1;
        exp[18] = 1'b1; exp[9]  = 1'b1; exp[0]  = 1'b1;
        exp[36] = 1'b1; exp[45] = 1'b1; exp[54] = 1'b1; exp[63] = 1'b1;
        exp[34] = 1'b1; exp[41] = 1'b1; exp[48] = 1'b1;
        check_eq("queen_mask", possible_moves, exp);

        run_gen("kcorner", 6'd0, 4'hC);
        exp = '0; exp[1] = 1'b1; exp[8] = 1'b1; exp[9] = 1'b1;
        check_eq("kcorner_mask", possible_moves, exp);

        clear_board();
        board[36] = 4'h2; board[18] = 4'h7; board[54] = 4'h1; board[27] = 4'hD;
        run_gen("bishop", 6'd36, 4'h2);
        exp = '0;
        exp[27] = 1'b1; exp[18] = 1'b1; exp[45] = 1'b1;
        exp[29] = 1'b1; exp[22] = 1'b1; exp[15] = 1'b1;
        exp[43] = 1'b1; exp[50] = 1'b1; exp[57] = 1'b1;
        check_eq("bishop_mask", possible_moves, exp);
        check_eq("bishop_54", {63'd0, possible_moves[54]}, 64'd0);

        run_gen("empty0", 6'd10, 4'h0);
        check_eq("empty0_mask", possible_moves, 64'd0);
        run_gen("emptyD", 6'd10, 4'hD);
        check_eq("emptyD_mask", possible_moves, 64'd0);

        // King on its home square with king-side castling available.
        clear_board();
        board[60] = 4'h6; board[63] = 4'h4;
        white_castle = 1'b0;
        run_gen("castle", 6'd60, 4'h6);
        exp = '0;
        exp[51] = 1'b1; exp[52] = 1'b1; exp[53] = 1'b1; exp[59] = 1'b1; exp[61] = 1'b1;
`ifdef MOVEGEN_CASTLE_EN
        exp[62] = 1'b1;
`endif
        check_eq("castle_mask", possible_moves, exp);
        exp[62] = 1'b0;
        white_castle = 1'b1;
        run_gen("castled", 6'd60, 4'h6);
        check_eq("castled_mask", possible_moves, exp);
        check_eq("castled_62", {63'd0, possible_moves[62]}, 64'd0);
        white_castle = 1'b0;

        // Reset in the middle of a generation.
        clear_board();
        @(negedge clk);
        sel_pos = 6'd27; sel_code = 4'h4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("mid_rst_done", {63'd0, done}, 64'd0);
        check_eq("mid_rst_mask", possible_moves, 64'd0);
        rst_n = 1'b1;

        // A second start while busy must not disturb the running request.
        @(negedge clk);
        sel_pos = 6'd27; sel_code = 4'h4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        sel_pos = 6'd0; sel_code = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart");
        check_eq("restart_mask", possible_moves, rook27);

        // Start coincident with done is ignored.
        sel_pos = 6'd0; sel_code = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_at_done_busy", {63'd0, busy}, 64'd0);
        check_eq("start_at_done_mask", possible_moves, rook27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
